// File: rtl/irrigation_zone_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irrigation_zone_scheduler: round-robin multi-zone irrigation controller  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module irrigation_zone_scheduler #(
  parameter int ZONES        = 4,
  parameter int TICK_DIV     = 1000,
  parameter int SETTLE_TICKS = 4,
  parameter int RUN_TICKS    = 16,
  parameter int FILTER_TICKS = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       low_water_level,
  input  logic                       mid_water_level,
  input  logic                       high_water_level,
  input  logic [ZONES-1:0]           earth_humidity,
  input  logic                       air_humidity,
  input  logic                       low_temperature,
  input  logic                       enable,
  output logic                       water_supply_valvule,
  output logic [ZONES-1:0]           zone_valvule,
  output logic                       splinker_bomb,
  output logic                       dripper_valvule,
  output logic [$clog2(ZONES)-1:0]   active_zone,
  output logic                       conflicting_values,
  output logic                       alarm
);

  localparam int c_ZW   = $clog2(ZONES);
  localparam int c_TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_PMAX = (SETTLE_TICKS > RUN_TICKS) ? SETTLE_TICKS : RUN_TICKS;
  localparam int c_PW   = $clog2(c_PMAX + 1);
  localparam int c_FW   = $clog2(FILTER_TICKS + 1);
  localparam int c_NS   = ZONES + 6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    SETTLE   = 3'd2,
    IRRIGATE = 3'd3,
    FAULT    = 3'd4
  } state_t;

  logic [c_NS-1:0]  async_w, sync1_q, sync2_q;
  logic [ZONES-1:0] hum_s;
  logic             low_s, mid_s, high_s, air_s, lt_s, en_s;

  state_t           state_q, state_d;
  logic [c_ZW-1:0]  active_q, active_d, last_q, last_d;
  logic             mode_q, mode_d;
  logic [c_PW-1:0]  phase_q, phase_d;
  logic [c_TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [c_FW-1:0]  filt_q, filt_d;
  logic             conflict_q, conflict_d;
  logic             refill_q, refill_d;
  logic [ZONES-1:0] zone_q, zone_d;
  logic             spk_q, spk_d, drip_q, drip_d, wsv_q, wsv_d, alarm_q, alarm_d;

  logic             tick_w, raw_conflict_w, sprinkler_w, found_w, exit_w;
  logic [c_ZW-1:0]  sel_w, cand_w;
  int               idx_w;

  assign async_w = {enable, low_temperature, air_humidity,
                    high_water_level, mid_water_level, low_water_level, earth_humidity};
  assign hum_s   = sync2_q[ZONES-1:0];
  assign low_s   = sync2_q[ZONES];
  assign mid_s   = sync2_q[ZONES+1];
  assign high_s  = sync2_q[ZONES+2];
  assign air_s   = sync2_q[ZONES+3];
  assign lt_s    = sync2_q[ZONES+4];
  assign en_s    = sync2_q[ZONES+5];

  assign tick_w         = (tick_cnt_q == c_TW'(TICK_DIV - 1));
  assign raw_conflict_w = (high_s & ~mid_s) | (mid_s & ~low_s) | (high_s & ~low_s);
  assign sprinkler_w    = mid_s & ~air_s & ~lt_s;
  assign exit_w         = ~en_s | ~low_s | hum_s[active_q];

  // Round-robin search for the first dry zone after the last one served
  always_comb begin
    found_w = 1'b0;
    sel_w   = last_q;
    idx_w   = 0;
    cand_w  = '0;
    for (int i = 1; i <= ZONES; i++) begin
      idx_w = int'(last_q) + i;
      if (idx_w >= ZONES) idx_w = idx_w - ZONES;
      cand_w = c_ZW'(idx_w);
      if (!found_w && !hum_s[cand_w]) begin
        found_w = 1'b1;
        sel_w   = cand_w;
      end
    end
  end

  always_comb begin
    filt_d = filt_q;
    if (!raw_conflict_w)
      filt_d = '0;
    else if (tick_w && filt_q != c_FW'(FILTER_TICKS))
      filt_d = filt_q + 1'b1;
    conflict_d = raw_conflict_w & (conflict_q | (filt_d == c_FW'(FILTER_TICKS)));

    refill_d = refill_q;
    if (!low_s)
      refill_d = 1'b1;
    else if (high_s)
      refill_d = 1'b0;

    if (state_q == SELECT || tick_w)
      tick_cnt_d = '0;
    else
      tick_cnt_d = tick_cnt_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    last_d   = last_q;
    mode_d   = mode_q;
    phase_d  = phase_q;
    if (conflict_q) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_s && low_s && (|(~hum_s)))
            state_d = SELECT;
        end
        SELECT: begin
          phase_d = '0;
          if (found_w) begin
            active_d = sel_w;
            mode_d   = sprinkler_w;
            state_d  = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
        SETTLE: begin
          if (exit_w) begin
            last_d  = active_q;
            state_d = IDLE;
          end else if (tick_w) begin
            if (phase_q == c_PW'(SETTLE_TICKS - 1)) begin
              phase_d = '0;
              state_d = IRRIGATE;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end
        IRRIGATE: begin
          if (exit_w || (tick_w && phase_q == c_PW'(RUN_TICKS - 1))) begin
            last_d  = active_q;
            state_d = IDLE;
          end else if (tick_w) begin
            phase_d = phase_q + 1'b1;
          end
        end
        FAULT:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from next state so they change on the same edge as the FSM
  always_comb begin
    zone_d = '0;
    if (state_d == SETTLE || state_d == IRRIGATE)
      zone_d[active_d] = 1'b1;
    spk_d   = (state_d == IRRIGATE) &  mode_d;
    drip_d  = (state_d == IRRIGATE) & ~mode_d;
    wsv_d   = refill_d & ~conflict_d & (state_d != FAULT);
    alarm_d = conflict_d | ~mid_s;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      state_q    <= IDLE;
      active_q   <= '0;
      last_q     <= c_ZW'(ZONES - 1);
      mode_q     <= 1'b0;
      phase_q    <= '0;
      tick_cnt_q <= '0;
      filt_q     <= '0;
      conflict_q <= 1'b0;
      refill_q   <= 1'b0;
      zone_q     <= '0;
      spk_q      <= 1'b0;
      drip_q     <= 1'b0;
      wsv_q      <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      sync1_q    <= async_w;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      active_q   <= active_d;
      last_q     <= last_d;
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      tick_cnt_q <= tick_cnt_d;
      filt_q     <= filt_d;
      conflict_q <= conflict_d;
      refill_q   <= refill_d;
      zone_q     <= zone_d;
      spk_q      <= spk_d;
      drip_q     <= drip_d;
      wsv_q      <= wsv_d;
      alarm_q    <= alarm_d;
    end
  end

  assign water_supply_valvule = wsv_q;
  assign zone_valvule         = zone_q;
  assign splinker_bomb        = spk_q;
  assign dripper_valvule      = drip_q;
  assign active_zone          = active_q;
  assign conflicting_values   = conflict_q;
  assign alarm                = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_irrigation_zone_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_irrigation_zone_scheduler: directed bench for the zone scheduler      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_irrigation_zone_scheduler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       low_l, mid_l, high_l, air_h, low_t, en;
  logic [3:0] hum;
  logic       wsv, spk, drip, conf, alm;
  logic [3:0] zone;
  logic [1:0] act;

  int n_checks = 0;
  int n_errors = 0;

  irrigation_zone_scheduler #(
    .ZONES(4), .TICK_DIV(1), .SETTLE_TICKS(2), .RUN_TICKS(5), .FILTER_TICKS(3)
  ) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .low_water_level      (low_l),
    .mid_water_level      (mid_l),
    .high_water_level     (high_l),
    .earth_humidity       (hum),
    .air_humidity         (air_h),
    .low_temperature      (low_t),
    .enable               (en),
    .water_supply_valvule (wsv),
    .zone_valvule         (zone),
    .splinker_bomb        (spk),
    .dripper_valvule      (drip),
    .active_zone          (act),
    .conflicting_values   (conf),
    .alarm                (alm)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      chk("excl_act", 32'(spk & drip), 32'd0);
      chk("onehot_zone", 32'($onehot0(zone)), 32'd1);
    end
  end

  initial begin
    reset_n = 1'b0;
    low_l = 1'b1; mid_l = 1'b1; high_l = 1'b1;
    air_h = 1'b0; low_t = 1'b0; en = 1'b1; hum = 4'b0000;
    #12;
    chk("rst_outputs", {20'd0, wsv, zone, spk, drip, act, conf, alm}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Round-robin visits, 9-cycle period: 2 settle + 5 run + idle + select
    cyc(4);
    chk("v0_zone", 32'(zone), 32'h1);
    chk("v0_act", 32'(act), 32'd0);
    chk("v0_settle_spk", 32'(spk), 32'd0);
    cyc(1);
    chk("v0_settle2_spk", 32'(spk), 32'd0);
    cyc(1);
    chk("v0_run_spk", 32'(spk), 32'd1);
    chk("v0_run_drip", 32'(drip), 32'd0);
    cyc(4);
    chk("v0_run5_spk", 32'(spk), 32'd1);
    chk("v0_run5_zone", 32'(zone), 32'h1);
    cyc(1);
    chk("v0_end_zone", 32'(zone), 32'h0);
    chk("v0_end_spk", 32'(spk), 32'd0);
    cyc(2);
    chk("v1_zone", 32'(zone), 32'h2);
    chk("v1_act", 32'(act), 32'd1);
    cyc(9);
    chk("v2_zone", 32'(zone), 32'h4);
    cyc(9);
    chk("v3_zone", 32'(zone), 32'h8);
    cyc(9);
    chk("wrap_zone", 32'(zone), 32'h1);
    chk("wrap_act", 32'(act), 32'd0);

    // Zone 2 turns wet during its run
    cyc(18);
    chk("z2_settle", 32'(zone), 32'h4);
    cyc(3);
    hum = 4'b0100;
    cyc(2);
    chk("wet_still_spk", 32'(spk), 32'd1);
    cyc(1);
    chk("wet_drop_zone", 32'(zone), 32'h0);
    chk("wet_drop_spk", 32'(spk), 32'd0);
    cyc(2);
    chk("after_wet_zone", 32'(zone), 32'h8);
    chk("after_wet_act", 32'(act), 32'd3);
    hum = 4'b1111;
    cyc(5);
    chk("all_wet_idle", 32'(zone), 32'h0);

    // Level conflict shorter than the filter
    mid_l = 1'b0;
    cyc(2);
    mid_l = 1'b1;
    cyc(1);
    chk("short_alarm", 32'(alm), 32'd1);
    chk("short_conf_a", 32'(conf), 32'd0);
    cyc(1);
    chk("short_conf_b", 32'(conf), 32'd0);
    cyc(2);
    chk("short_conf_c", 32'(conf), 32'd0);

    // Conflict lasting the full filter length
    mid_l = 1'b0;
    cyc(4);
    chk("long_conf_2t", 32'(conf), 32'd0);
    cyc(1);
    chk("long_conf_set", 32'(conf), 32'd1);
    chk("long_alarm", 32'(alm), 32'd1);
    cyc(1);
    chk("fault_state", 32'(dut.state_q), 32'd4);
    chk("fault_zone", 32'(zone), 32'h0);
    chk("fault_wsv", 32'(wsv), 32'd0);
    mid_l = 1'b1;
    cyc(3);
    chk("conf_clear", 32'(conf), 32'd0);
    chk("fault_hold", 32'(dut.state_q), 32'd4);
    cyc(1);
    chk("fault_to_idle", 32'(dut.state_q), 32'd0);

    // Refill hysteresis with dry zones waiting
    low_l = 1'b0; mid_l = 1'b0; high_l = 1'b0;
    hum = 4'b0000;
    cyc(3);
    chk("refill_on", 32'(wsv), 32'd1);
    cyc(2);
    chk("empty_no_zone", 32'(zone), 32'h0);
    chk("empty_idle", 32'(dut.state_q), 32'd0);
    low_l = 1'b1; mid_l = 1'b1;
    cyc(3);
    chk("refill_hold_a", 32'(wsv), 32'd1);
    cyc(1);
    chk("refill_hold_b", 32'(wsv), 32'd1);
    chk("resume_zone0", 32'(zone), 32'h1);
    high_l = 1'b1;
    cyc(2);
    chk("refill_hold_c", 32'(wsv), 32'd1);
    chk("resume_spk", 32'(spk), 32'd1);
    cyc(1);
    chk("refill_off", 32'(wsv), 32'd0);

    // Cold weather selects the dripper, latched for the whole visit
    low_t = 1'b1;
    cyc(6);
    chk("cold_zone1", 32'(zone), 32'h2);
    chk("cold_act", 32'(act), 32'd1);
    cyc(2);
    chk("cold_drip", 32'(drip), 32'd1);
    chk("cold_spk", 32'(spk), 32'd0);
    low_t = 1'b0;
    cyc(3);
    chk("latched_drip", 32'(drip), 32'd1);
    chk("latched_spk", 32'(spk), 32'd0);
    cyc(6);
    chk("warm_spk", 32'(spk), 32'd1);
    chk("warm_drip", 32'(drip), 32'd0);
    chk("warm_act", 32'(act), 32'd2);

    // Asynchronous reset in the middle of a run
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_outputs", {20'd0, wsv, zone, spk, drip, act, conf, alm}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cyc(4);
    chk("post_rst_zone", 32'(zone), 32'h1);
    chk("post_rst_act", 32'(act), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
